fifo_stream_reader: RTL and testbench

- Sits directly downstream of the synchronous FIFO (fifo_top).
- Issues fifo_read_req and absorbs the FIFO's 1-cycle RAM read latency into a 2-entry output buffer.
- Presents the words as a valid/ready stream to the next consumer, sustaining 1 word/cycle under continuous m_ready.
- Provides a synchronous flush and a delivered-word counter.

---
 rtl/fifo_stream_reader_pkg.sv | 18 +
 rtl/fifo_stream_reader_if.sv | 30 +++
 rtl/fifo_stream_reader_stream_skid_buf.sv | 63 ++++++
 rtl/fifo_stream_reader.sv | 64 ++++++
 tb/tb_fifo_stream_reader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the small stream adapters that sit behind the
// memory-directory FIFOs (2-entry output buffering, 1-cycle read latency).
package fifo_stream_reader_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_PTR_W = 1;

  typedef logic [1:0] occ_t;

  // True when a new read can be issued without the buffer overflowing
  // once every word already in flight has landed.
  function automatic logic has_room(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] w_used;
    w_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return w_used < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-side and output-stream signals of fifo_stream_reader.
// master = the reader itself, slave = the FIFO/consumer environment.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_read_req;
  logic [WIDTH-1:0] fifo_read_data;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    input  m_ready,
    output fifo_read_req,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    output m_ready,
    input  fifo_read_req,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader_stream_skid_buf.sv
// Two-entry register buffer: words are pushed at the write pointer and presented
// at the read pointer; clear empties it and re-aligns both pointers.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output occ_t             occ
);

  logic [BUF_PTR_W-1:0]              r_wr_ptr;
  logic [BUF_PTR_W-1:0]              r_rd_ptr;
  occ_t                              r_occ;
  logic [BUF_DEPTH-1:0][WIDTH-1:0]   w_words;

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] r_word;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_word <= '0;
      end else if (push && !clear && (r_wr_ptr == BUF_PTR_W'(gi))) begin
        r_word <= push_data;
      end
    end

    assign w_words[gi] = r_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + BUF_PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + BUF_PTR_W'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      r_occ <= r_occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign m_valid = (r_occ != '0);
  assign m_data  = w_words[r_rd_ptr];
  assign occ     = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from fifo_top, hides its 1-cycle read latency behind a 2-entry
// buffer and presents them as a valid/ready stream with a delivered-word count.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic [COUNT_W-1:0]   word_count
);

  occ_t               w_occ;
  logic               w_valid;
  logic [WIDTH-1:0]   w_data;
  logic               w_pop;
  logic               w_push;
  logic               w_read_req;
  logic               r_inflight;
  logic [COUNT_W-1:0] r_word_count;

  assign w_pop = w_valid && bus.m_ready;

  // m_ready feeds the request directly so a slot freed this cycle can be
  // refilled at once; rst is included so the request drops asynchronously.
  assign w_read_req = !rst && !flush && !bus.fifo_empty && has_room(w_occ, r_inflight, w_pop);

  assign w_push = r_inflight && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_inflight <= w_read_req;
      if (w_pop) begin
        r_word_count <= r_word_count + COUNT_W'(1);
      end
    end
  end

  stream_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (w_push),
    .push_data(bus.fifo_read_data),
    .pop      (w_pop),
    .m_valid  (w_valid),
    .m_data   (w_data),
    .occ      (w_occ)
  );

  assign bus.fifo_read_req = w_read_req;
  assign bus.m_valid       = w_valid;
  assign bus.m_data        = w_data;
  assign word_count        = r_word_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model, table-driven vectors,
// directed corner sequences and a randomized run against a scoreboard model.
module tb_fifo_stream_reader;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic [COUNT_W-1:0] word_count;

  logic               tb_empty = 1'b1;
  logic [WIDTH-1:0]   tb_rdata = '0;
  logic               tb_ready = 1'b0;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

  assign bus.fifo_empty     = tb_empty;
  assign bus.fifo_read_data = tb_rdata;
  assign bus.m_ready        = tb_ready;

  fifo_stream_reader #(
    .WIDTH  (WIDTH),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- FIFO model (fifo_top stand-in) ----------------
  logic [WIDTH-1:0] load_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  int               ld_idx = 0;

  always @(posedge clk) begin
    if (bus.fifo_read_req && fifo_q.size() > 0)
      tb_rdata <= fifo_q.pop_front();
    else
      tb_rdata <= WIDTH'($urandom);
    while (ld_idx < load_q.size()) begin
      fifo_q.push_back(load_q[ld_idx]);
      ld_idx++;
    end
    tb_empty <= (fifo_q.size() == 0);
  end

  task automatic load_words(input int n, input logic [WIDTH-1:0] base);
    for (int j = 0; j < n; j++) load_q.push_back(base + WIDTH'(j));
  endtask

  // ---------------- scoreboard model ----------------
  // A word read from the FIFO in cycle N becomes visible on the output in N+2
  // and leaves in order; flush discards everything read but not yet delivered.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               avail;
  } exp_t;

  exp_t               exp_q[$];
  int                 cyc = 0;
  logic [COUNT_W-1:0] wc_model = '0;
  logic               prev_hold = 1'b0;
  logic [WIDTH-1:0]   prev_data = '0;
  logic               mon_exp_valid;
  logic               mon_pop;
  logic               mon_exp_req;
  int                 mon_held;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      wc_model  = '0;
      prev_hold = 1'b0;
    end else begin
      mon_exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check($sformatf("mon_valid@%0d", cyc), 32'(bus.m_valid), 32'(mon_exp_valid));
      if (mon_exp_valid)
        check($sformatf("mon_data@%0d", cyc), 32'(bus.m_data), 32'(exp_q[0].data));
      if (prev_hold && bus.m_valid)
        check($sformatf("mon_hold@%0d", cyc), 32'(bus.m_data), 32'(prev_data));
      check($sformatf("mon_count@%0d", cyc), 32'(word_count), 32'(wc_model));
      mon_pop     = mon_exp_valid && tb_ready;
      mon_held    = exp_q.size() - (mon_pop ? 1 : 0);
      mon_exp_req = !flush && !tb_empty && (mon_held < 2);
      check($sformatf("mon_req@%0d", cyc), 32'(bus.fifo_read_req), 32'(mon_exp_req));
      if (mon_pop) begin
        exp_q.delete(0);
        wc_model = wc_model + COUNT_W'(1);
      end
      if (flush) exp_q.delete();
      if (bus.fifo_read_req && fifo_q.size() > 0)
        exp_q.push_back('{data: fifo_q[0], avail: cyc + 2});
      prev_hold = bus.m_valid && !tb_ready && !flush;
      prev_data = bus.m_data;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic             ready;
    logic             flush;
    int               load;
    logic             req;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [COUNT_W-1:0] wc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // backpressure: 5 words, m_ready low, then released
    tbl[0]  = '{0, 0, 5, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 8'h00, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 8'h00, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 8'h01, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 8'h01, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 8'h01, 0};
    tbl[6]  = '{1, 0, 0, 1, 1, 8'h01, 0};
    tbl[7]  = '{1, 0, 0, 1, 1, 8'h02, 1};
    tbl[8]  = '{1, 0, 0, 1, 1, 8'h03, 2};
    tbl[9]  = '{1, 0, 0, 0, 1, 8'h04, 3};
    tbl[10] = '{1, 0, 0, 0, 1, 8'h05, 4};
    // flush: 4 words, flush at occ=2, words 3..4 survive in the FIFO
    tbl[11] = '{0, 0, 4, 0, 0, 8'h00, 5};
    tbl[12] = '{0, 0, 0, 1, 0, 8'h00, 5};
    tbl[13] = '{0, 0, 0, 1, 0, 8'h00, 5};
    tbl[14] = '{0, 0, 0, 0, 1, 8'h01, 5};
    tbl[15] = '{0, 1, 0, 0, 1, 8'h01, 5};
    tbl[16] = '{0, 0, 0, 1, 0, 8'h00, 5};
    tbl[17] = '{1, 0, 0, 1, 0, 8'h00, 5};
    tbl[18] = '{1, 0, 0, 0, 1, 8'h03, 5};
    tbl[19] = '{1, 0, 0, 0, 1, 8'h04, 6};
    tbl[20] = '{1, 0, 0, 0, 0, 8'h00, 7};

    // reset then idle
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        @(posedge clk);
        #1 rst = 1'b0;
      end
      @(negedge clk);
      check($sformatf("idle%0d_req", k), 32'(bus.fifo_read_req), 32'd0);
      check($sformatf("idle%0d_valid", k), 32'(bus.m_valid), 32'd0);
      check($sformatf("idle%0d_data", k), 32'(bus.m_data), 32'd0);
      check($sformatf("idle%0d_count", k), 32'(word_count), 32'd0);
    end
    @(posedge clk);
    #1;

    // table-driven backpressure and flush vectors
    for (int k = 0; k < NV; k++) begin
      tb_ready = tbl[k].ready;
      flush    = tbl[k].flush;
      load_words(tbl[k].load, 8'h01);
      @(negedge clk);
      check($sformatf("tbl%0d_req", k), 32'(bus.fifo_read_req), 32'(tbl[k].req));
      check($sformatf("tbl%0d_valid", k), 32'(bus.m_valid), 32'(tbl[k].valid));
      if (tbl[k].valid)
        check($sformatf("tbl%0d_data", k), 32'(bus.m_data), 32'(tbl[k].data));
      check($sformatf("tbl%0d_count", k), 32'(word_count), 32'(tbl[k].wc));
      @(posedge clk);
      #1;
    end

    // single word 0xA5
    tb_ready = 1'b1;
    load_words(1, 8'hA5);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("single%0d_req", c), 32'(bus.fifo_read_req), 32'(c == 0));
      check($sformatf("single%0d_valid", c), 32'(bus.m_valid), 32'(c == 2));
      if (c == 2) check("single_data", 32'(bus.m_data), 32'hA5);
      @(posedge clk);
      #1;
    end
    check("single_count", 32'(word_count), 32'd8);

    // streaming 0x01..0x08 at one word per cycle
    load_words(8, 8'h01);
    @(posedge clk);
    #1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check($sformatf("stream%0d_req", c), 32'(bus.fifo_read_req), 32'(c < 8));
      check($sformatf("stream%0d_valid", c), 32'(bus.m_valid), 32'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9)
        check($sformatf("stream%0d_data", c), 32'(bus.m_data), 32'(c - 1));
      @(posedge clk);
      #1;
    end
    check("stream_count", 32'(word_count), 32'd16);

    // asynchronous reset in the middle of a stream
    load_words(8, 8'h40);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    check("prerst_req", 32'(bus.fifo_read_req), 32'd1);
    check("prerst_valid", 32'(bus.m_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_req", 32'(bus.fifo_read_req), 32'd0);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 12; c++) @(posedge clk);
    #1;
    check("postrst_count", 32'(word_count), 32'd5);
    check("postrst_valid", 32'(bus.m_valid), 32'd0);

    // randomized traffic, flushes and backpressure against the scoreboard
    for (int c = 0; c < 1500; c++) begin
      tb_ready = ($urandom_range(0, 3) < ((c / 250) % 4)) || (c % 250 > 240);
      flush    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 12) begin
        for (int j = $urandom_range(1, 4); j > 0; j--) load_q.push_back(WIDTH'($urandom));
      end
      @(posedge clk);
      #1;
    end

    // drain everything, bounded
    flush    = 1'b0;
    tb_ready = 1'b1;
    begin
      int budget;
      budget = 200;
      while ((fifo_q.size() > 0 || exp_q.size() > 0 || bus.m_valid) && budget > 0) begin
        @(posedge clk);
        #1;
        budget--;
      end
      check("drain_budget", 32'(budget > 0), 32'd1);
    end
    check("drain_fifo_left", 32'(fifo_q.size()), 32'd0);
    check("drain_exp_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
